// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the BCD stopwatch
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAP  = 2'd2
    } state_t;

    // Highest value of a full decimal digit and of the seconds-tens digit
    localparam logic [3:0] CS_MAX    = 4'd9;
    localparam logic [3:0] SEC_T_MAX = 4'd5;

    localparam int DIGIT_W   = 4;
    localparam int CS_U_LSB  = 0;
    localparam int CS_T_LSB  = 4;
    localparam int SEC_U_LSB = 8;
    localparam int SEC_T_LSB = 12;
    localparam int MIN_U_LSB = 16;
    localparam int MIN_T_LSB = 20;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - input synchroniser with one-cycle rising-edge pulse
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clkin,
    input  logic clrn,
    input  logic din,
    output logic pulse
);

    localparam int TOP = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic                   armed_q;

    // Shift the input through the synchroniser; fill_q marks when the last
    // stage holds a real sample rather than a reset zero, and armed_q only
    // sets once a genuine low has been seen, so a level held high across
    // reset release never looks like an edge.
    always_ff @(posedge clkin or negedge clrn) begin
        if (!clrn) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q  <= sync_q[TOP];
            armed_q <= armed_q | (fill_q[TOP] & ~sync_q[TOP]);
        end
    end

    assign pulse = sync_q[TOP] & ~prev_q & armed_q;

endmodule

// File: rtl/stopwatch_bcd.sv
// rtl/stopwatch_bcd.sv - MM:SS.CC BCD stopwatch with start/stop and lap/clear
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MIN     = 59
) (
    input  logic        clkin,
    input  logic        clrn,
    input  logic        tick_in,
    input  logic        startstop,
    input  logic        lap,
    output logic [23:0] disp,
    output logic        running,
    output logic        lap_active,
    output logic        ovf
);

    localparam logic [3:0] MIN_T_MAX = 4'(MAX_MIN / 10);
    localparam logic [3:0] MIN_U_MAX = 4'(MAX_MIN % 10);

    logic tick_p, ss_p, lap_p;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_tick (
        .clkin(clkin), .clrn(clrn), .din(tick_in), .pulse(tick_p)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
        .clkin(clkin), .clrn(clrn), .din(startstop), .pulse(ss_p)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lap (
        .clkin(clkin), .clrn(clrn), .din(lap), .pulse(lap_p)
    );

    state_t      state_q, state_d;
    logic [23:0] count_q, count_d, count_inc;
    logic [23:0] snap_q, snap_d;
    logic        wrap, ovf_d;

    logic [3:0] cs_u, cs_t, sec_u, sec_t, min_u, min_t;
    logic       c0, c1, c2, c3, min_at_max;

    assign cs_u  = count_q[CS_U_LSB  +: DIGIT_W];
    assign cs_t  = count_q[CS_T_LSB  +: DIGIT_W];
    assign sec_u = count_q[SEC_U_LSB +: DIGIT_W];
    assign sec_t = count_q[SEC_T_LSB +: DIGIT_W];
    assign min_u = count_q[MIN_U_LSB +: DIGIT_W];
    assign min_t = count_q[MIN_T_LSB +: DIGIT_W];

    // Ripple-carry BCD increment: a digit advances only when every lower
    // digit is at its maximum; the whole count wraps at MAX_MIN:59.99.
    always_comb begin
        count_inc  = count_q;
        wrap       = 1'b0;
        c0         = (cs_u == CS_MAX);
        c1         = c0 && (cs_t == CS_MAX);
        c2         = c1 && (sec_u == CS_MAX);
        c3         = c2 && (sec_t == SEC_T_MAX);
        min_at_max = (min_t == MIN_T_MAX) && (min_u == MIN_U_MAX);

        count_inc[CS_U_LSB +: DIGIT_W] = c0 ? 4'd0 : cs_u + 4'd1;
        if (c0) begin
            count_inc[CS_T_LSB +: DIGIT_W] = c1 ? 4'd0 : cs_t + 4'd1;
        end
        if (c1) begin
            count_inc[SEC_U_LSB +: DIGIT_W] = c2 ? 4'd0 : sec_u + 4'd1;
        end
        if (c2) begin
            count_inc[SEC_T_LSB +: DIGIT_W] = c3 ? 4'd0 : sec_t + 4'd1;
        end
        if (c3) begin
            if (min_at_max) begin
                count_inc = '0;
                wrap      = 1'b1;
            end else if (min_u == CS_MAX) begin
                count_inc[MIN_U_LSB +: DIGIT_W] = 4'd0;
                count_inc[MIN_T_LSB +: DIGIT_W] = min_t + 4'd1;
            end else begin
                count_inc[MIN_U_LSB +: DIGIT_W] = min_u + 4'd1;
            end
        end
    end

    // Next state and datapath: ticks use the state at the start of the
    // cycle, start/stop outranks lap, and a stopped lap press clears.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        snap_d  = snap_q;
        ovf_d   = 1'b0;

        if (tick_p && (state_q != ST_STOP)) begin
            count_d = count_inc;
            ovf_d   = wrap;
        end

        case (state_q)
            ST_STOP: begin
                if (ss_p) begin
                    state_d = ST_RUN;
                end else if (lap_p) begin
                    count_d = '0;
                end
            end
            ST_RUN: begin
                if (ss_p) begin
                    state_d = ST_STOP;
                end else if (lap_p) begin
                    state_d = ST_LAP;
                    snap_d  = count_q;
                end
            end
            ST_LAP: begin
                if (ss_p) begin
                    state_d = ST_STOP;
                end else if (lap_p) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    // State register
    always_ff @(posedge clkin or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // Count, snapshot and registered outputs all follow the next state
    always_ff @(posedge clkin or negedge clrn) begin
        if (!clrn) begin
            count_q    <= '0;
            snap_q     <= '0;
            disp       <= '0;
            running    <= 1'b0;
            lap_active <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            count_q    <= count_d;
            snap_q     <= snap_d;
            disp       <= (state_d == ST_LAP) ? snap_d : count_d;
            running    <= (state_d != ST_STOP);
            lap_active <= (state_d == ST_LAP);
            ovf        <= ovf_d;
        end
    end

endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb/tb_stopwatch_bcd.sv - self-checking bench for stopwatch_bcd
module tb_stopwatch_bcd;

    localparam int SYNC    = 2;
    localparam int MAXM    = 1;
    localparam int WRAP_CS = (MAXM + 1) * 6000;
    localparam int M_STOP  = 0;
    localparam int M_RUN   = 1;
    localparam int M_LAP   = 2;

    logic        clkin = 1'b0;
    logic        clrn = 1'b0;
    logic        tick_in = 1'b0;
    logic        startstop = 1'b0;
    logic        lap = 1'b0;
    logic [23:0] disp;
    logic        running, lap_active, ovf;

    int n_checks = 0;
    int n_fail = 0;

    int m_state = M_STOP;
    int m_cnt = 0;
    int m_snap = 0;

    stopwatch_bcd #(.SYNC_STAGES(SYNC), .MAX_MIN(MAXM)) dut (
        .clkin(clkin), .clrn(clrn), .tick_in(tick_in), .startstop(startstop),
        .lap(lap), .disp(disp), .running(running), .lap_active(lap_active), .ovf(ovf)
    );

    always #5 clkin = ~clkin;

    function automatic logic [23:0] to_bcd(input int c);
        int m, s, cc;
        m  = c / 6000;
        s  = (c / 100) % 60;
        cc = c % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    function automatic logic [23:0] exp_disp();
        return (m_state == M_LAP) ? to_bcd(m_snap) : to_bcd(m_cnt);
    endfunction

    task automatic model_event(input bit t, input bit s, input bit l);
        int old;
        old = m_cnt;
        if (t && m_state != M_STOP) m_cnt = (m_cnt + 1) % WRAP_CS;
        if (s) begin
            m_state = (m_state == M_STOP) ? M_RUN : M_STOP;
        end else if (l) begin
            if (m_state == M_STOP) m_cnt = 0;
            else if (m_state == M_RUN) begin
                m_snap  = old;
                m_state = M_LAP;
            end else m_state = M_RUN;
        end
    endtask

    task automatic drive_event(input bit t, input bit s, input bit l, input int hi, input int lo);
        tick_in = t;
        startstop = s;
        lap = l;
        repeat (hi) @(negedge clkin);
        tick_in = 1'b0;
        startstop = 1'b0;
        lap = 1'b0;
        repeat (lo) @(negedge clkin);
        model_event(t, s, l);
    endtask

    task automatic ticks(input int n, input bit fast);
        for (int i = 0; i < n; i++) begin
            if (fast) drive_event(1'b1, 1'b0, 1'b0, 1, 1);
            else drive_event(1'b1, 1'b0, 1'b0, $urandom_range(1, 3), $urandom_range(1, 2));
        end
        repeat (SYNC + 2) @(negedge clkin);
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        tick_in = 1'b0;
        startstop = 1'b0;
        lap = 1'b0;
        m_state = M_STOP;
        m_cnt = 0;
        m_snap = 0;
        repeat (2) @(negedge clkin);
        clrn = 1'b1;
        repeat (SYNC + 3) @(negedge clkin);
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        startstop = 1'b1;
        m_state = M_STOP;
        m_cnt = 0;
        repeat (3) @(negedge clkin);
        n_checks++;
        if (disp !== 24'h000000) begin n_fail++; $display("FAIL reset_disp_held: got %h expected 000000", disp); end
        clrn = 1'b1;
        repeat (50) @(negedge clkin);
        n_checks++;
        if (disp !== 24'h000000) begin n_fail++; $display("FAIL reset_disp: got %h expected 000000", disp); end
        n_checks++;
        if (running !== 1'b0 || lap_active !== 1'b0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got run=%b lap=%b ovf=%b expected 0 0 0", running, lap_active, ovf);
        end
        startstop = 1'b0;
        repeat (SYNC + 3) @(negedge clkin);
        n_checks++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL reset_release_no_start: got running=%b expected 0", running); end
    endtask

    task automatic test_count();
        do_reset();
        drive_event(1'b0, 1'b1, 1'b0, $urandom_range(1, 3), SYNC + 2);
        n_checks++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL count_running: got %b expected 1", running); end
        tick_in = 1'b1;
        repeat (SYNC) @(negedge clkin);
        n_checks++;
        if (disp !== 24'h000000) begin n_fail++; $display("FAIL count_latency_early: got %h expected 000000", disp); end
        @(negedge clkin);
        n_checks++;
        if (disp !== 24'h000001) begin n_fail++; $display("FAIL count_latency: got %h expected 000001", disp); end
        tick_in = 1'b0;
        @(negedge clkin);
        model_event(1'b1, 1'b0, 1'b0);
        ticks(122, 1'b0);
        n_checks++;
        if (disp !== 24'h000123) begin n_fail++; $display("FAIL count_123: got %h expected 000123", disp); end
        n_checks++;
        if (disp !== exp_disp()) begin n_fail++; $display("FAIL count_model: got %h expected %h", disp, exp_disp()); end
    endtask

    task automatic test_wrap();
        int ovf_seen;
        logic [23:0] at_ovf;
        do_reset();
        drive_event(1'b0, 1'b1, 1'b0, 1, SYNC + 2);
        ticks(WRAP_CS - 2, 1'b1);
        n_checks++;
        if (disp !== 24'h015998) begin n_fail++; $display("FAIL wrap_preload: got %h expected 015998", disp); end
        ticks(1, 1'b1);
        n_checks++;
        if (disp !== 24'h015999) begin n_fail++; $display("FAIL wrap_max: got %h expected 015999", disp); end
        ovf_seen = 0;
        at_ovf = 24'hFFFFFF;
        tick_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clkin);
            tick_in = 1'b0;
            if (ovf === 1'b1) begin
                ovf_seen++;
                at_ovf = disp;
            end
        end
        model_event(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (ovf_seen !== 1) begin n_fail++; $display("FAIL wrap_ovf_count: got %0d cycles expected 1", ovf_seen); end
        n_checks++;
        if (at_ovf !== 24'h000000) begin n_fail++; $display("FAIL wrap_disp_at_ovf: got %h expected 000000", at_ovf); end
        n_checks++;
        if (disp !== exp_disp() || running !== 1'b1) begin
            n_fail++; $display("FAIL wrap_after: got %h run=%b expected %h run=1", disp, running, exp_disp());
        end
    endtask

    task automatic test_lap();
        do_reset();
        drive_event(1'b0, 1'b1, 1'b0, 1, SYNC + 2);
        ticks(50, 1'b0);
        drive_event(1'b0, 1'b0, 1'b1, $urandom_range(1, 3), SYNC + 2);
        ticks(30, 1'b0);
        n_checks++;
        if (disp !== 24'h000050) begin n_fail++; $display("FAIL lap_frozen: got %h expected 000050", disp); end
        n_checks++;
        if (lap_active !== 1'b1 || running !== 1'b1) begin
            n_fail++; $display("FAIL lap_flags: got lap=%b run=%b expected 1 1", lap_active, running);
        end
        drive_event(1'b0, 1'b0, 1'b1, 1, SYNC + 2);
        n_checks++;
        if (disp !== 24'h000080) begin n_fail++; $display("FAIL lap_resume: got %h expected 000080", disp); end
        n_checks++;
        if (lap_active !== 1'b0) begin n_fail++; $display("FAIL lap_exit: got %b expected 0", lap_active); end
    endtask

    task automatic test_stop_clear();
        do_reset();
        drive_event(1'b0, 1'b1, 1'b0, 1, SYNC + 2);
        ticks(200, 1'b0);
        drive_event(1'b0, 1'b1, 1'b0, 2, SYNC + 2);
        ticks(5, 1'b0);
        n_checks++;
        if (disp !== 24'h000200 || running !== 1'b0) begin
            n_fail++; $display("FAIL stop_hold: got %h run=%b expected 000200 run=0", disp, running);
        end
        drive_event(1'b0, 1'b0, 1'b1, 2, SYNC + 2);
        n_checks++;
        if (disp !== 24'h000000) begin n_fail++; $display("FAIL stop_clear: got %h expected 000000", disp); end
        drive_event(1'b0, 1'b1, 1'b0, 1, SYNC + 2);
        ticks(7, 1'b0);
        drive_event(1'b0, 1'b1, 1'b1, 2, SYNC + 2);
        n_checks++;
        if (running !== 1'b0 || lap_active !== 1'b0 || disp !== 24'h000007) begin
            n_fail++; $display("FAIL ss_lap_same: got %h run=%b lap=%b expected 000007 0 0", disp, running, lap_active);
        end
    endtask

    task automatic test_random();
        int k;
        bit t, s, l;
        do_reset();
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 9);
            t = (k <= 4) || (k >= 8);
            s = (k == 5) || (k == 7) || (k == 8);
            l = (k == 6) || (k == 7) || (k == 9);
            drive_event(t, s, l, $urandom_range(1, 3), $urandom_range(SYNC + 2, SYNC + 4));
            n_checks++;
            if (disp !== exp_disp() || running !== (m_state != M_STOP) || lap_active !== (m_state == M_LAP)) begin
                n_fail++;
                $display("FAIL random_%0d op=%0d: got %h run=%b lap=%b expected %h run=%b lap=%b", i, k,
                         disp, running, lap_active, exp_disp(), m_state != M_STOP, m_state == M_LAP);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_event(1'b0, 1'b1, 1'b0, 1, SYNC + 2);
        ticks(1007, 1'b1);
        n_checks++;
        if (disp !== 24'h001007) begin n_fail++; $display("FAIL async_preload: got %h expected 001007", disp); end
        #2;
        clrn = 1'b0;
        #1;
        n_checks++;
        if (disp !== 24'h000000 || running !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got %h run=%b expected 000000 run=0", disp, running);
        end
        @(negedge clkin);
        clrn = 1'b1;
        repeat (SYNC + 3) @(negedge clkin);
    endtask

    initial begin
        @(negedge clkin);
        test_reset();
        test_count();
        test_wrap();
        test_lap();
        test_stop_clear();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
